// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, controller
// states and width-independent opcode classification helpers.
package alu_seq_pkg;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_ADD  = 5'd0;
    localparam opcode_t OP_ADDI = 5'd1;
    localparam opcode_t OP_SUB  = 5'd2;
    localparam opcode_t OP_SUBI = 5'd3;
    localparam opcode_t OP_MUL  = 5'd4;
    localparam opcode_t OP_MULI = 5'd5;
    localparam opcode_t OP_DIV  = 5'd6;
    localparam opcode_t OP_DIVI = 5'd7;
    localparam opcode_t OP_MOD  = 5'd8;
    localparam opcode_t OP_SLT  = 5'd9;
    localparam opcode_t OP_SLTI = 5'd10;
    localparam opcode_t OP_AND  = 5'd11;
    localparam opcode_t OP_ANDI = 5'd12;
    localparam opcode_t OP_OR   = 5'd13;
    localparam opcode_t OP_ORI  = 5'd14;
    localparam opcode_t OP_NOT  = 5'd15;
    localparam opcode_t OP_SRL  = 5'd16;
    localparam opcode_t OP_SLL  = 5'd17;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    // Multiply family runs on the iterative datapath in shift-add mode.
    function automatic logic is_mul_op(input opcode_t op);
        return (op == OP_MUL) || (op == OP_MULI);
    endfunction

    // Divide family (quotient or remainder) runs in restoring-divide mode.
    function automatic logic is_div_op(input opcode_t op);
        return (op == OP_DIV) || (op == OP_DIVI) || (op == OP_MOD);
    endfunction

    function automatic logic is_iterative(input opcode_t op);
        return is_mul_op(op) || is_div_op(op);
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative multiply/divide engine. One double-width shift register and one
// iteration counter are shared between shift-add multiply and restoring
// divide; the mode is latched at load time. The next-state value of the
// shift register is exported so the controller can capture the final
// result on the same edge as the last iteration.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             mode_mul,
    input  logic [WIDTH-1:0] load_lo,
    input  logic [WIDTH-1:0] load_operand,
    output logic             last,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   operand;
    logic [CW-1:0]      count;
    logic               running;
    logic               mode_reg;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rem;
    logic [WIDTH-1:0]   div_diff;
    logic               div_fits;

    // One iteration step: multiply adds the multiplicand into the upper half
    // when the current multiplier bit is set and shifts right; divide shifts
    // the next dividend bit into the partial remainder and subtracts the
    // divisor when it fits, shifting a quotient bit in from the right.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        div_rem  = acc[2*WIDTH-1:WIDTH-1];
        div_fits = (div_rem >= {1'b0, operand});
        div_diff = div_rem[WIDTH-1:0] - operand;
        if (mode_reg) begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end else if (div_fits) begin
            acc_next = {div_diff, acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {acc[2*WIDTH-2:0], 1'b0};
        end
    end

    assign last   = running && (count == LAST_COUNT);
    assign res_lo = acc_next[WIDTH-1:0];
    assign res_hi = acc_next[2*WIDTH-1:WIDTH];

    // Load operands on accept, then run exactly WIDTH steps and stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            operand  <= '0;
            count    <= '0;
            running  <= 1'b0;
            mode_reg <= 1'b0;
        end else if (load) begin
            acc      <= {{WIDTH{1'b0}}, load_lo};
            operand  <= load_operand;
            mode_reg <= mode_mul;
            count    <= '0;
            running  <= 1'b1;
        end else if (running) begin
            acc <= acc_next;
            if (count == LAST_COUNT) begin
                count   <= '0;
                running <= 1'b0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU controller. Single-cycle operations complete on the
// accepting edge; multiply, divide and modulo hand off to the iterative
// engine and complete WIDTH cycles later. Results and flags are registered
// and held until the next accepted request. WIDTH must be a power of two
// and at least 8.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       opCode,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] dataC,
    output logic             zero,
    output logic             overflow,
    output logic             error
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    opcode_t          op_reg;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] single_res;
    logic             single_ovf;
    logic             single_err;
    logic             shift_big;
    logic [SHW-1:0]   shamt;
    logic             go_iter;
    logic             iter_load;
    logic             iter_last;
    logic [WIDTH-1:0] iter_lo;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_res;
    logic             iter_ovf;

    assign ready     = (state != EXEC);
    assign add_sum   = {1'b0, dataA} + {1'b0, dataB};
    assign shift_big = |dataB[WIDTH-1:SHW];
    assign shamt     = dataB[SHW-1:0];
    assign go_iter   = is_iterative(opCode) && !(is_div_op(opCode) && (dataB == '0));
    assign iter_load = start && ready && go_iter;

    alu_seq_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (iter_load),
        .mode_mul     (is_mul_op(opCode)),
        .load_lo      (is_mul_op(opCode) ? dataB : dataA),
        .load_operand (is_mul_op(opCode) ? dataA : dataB),
        .last         (iter_last),
        .res_lo       (iter_lo),
        .res_hi       (iter_hi)
    );

    // Result of every operation that completes on the accepting edge,
    // including divide-by-zero and unassigned opcodes, which report error.
    always_comb begin
        single_res = '0;
        single_ovf = 1'b0;
        single_err = 1'b0;
        case (opCode)
            OP_ADD, OP_ADDI: begin
                single_res = add_sum[WIDTH-1:0];
                single_ovf = add_sum[WIDTH];
            end
            OP_SUB, OP_SUBI: begin
                single_res = dataA - dataB;
                single_ovf = (dataA < dataB);
            end
            OP_MUL, OP_MULI: single_res = '0;
            OP_DIV, OP_DIVI, OP_MOD: single_err = 1'b1;
            OP_SLT, OP_SLTI: single_res = {{(WIDTH-1){1'b0}}, (dataA < dataB)};
            OP_AND, OP_ANDI: single_res = dataA & dataB;
            OP_OR,  OP_ORI:  single_res = dataA | dataB;
            OP_NOT:          single_res = ~dataA;
            OP_SRL:          single_res = shift_big ? '0 : (dataA >> shamt);
            OP_SLL:          single_res = shift_big ? '0 : (dataA << shamt);
            default:         single_err = 1'b1;
        endcase
    end

    // Pick the final iterative result: low product, quotient or remainder.
    always_comb begin
        iter_res = iter_lo;
        iter_ovf = 1'b0;
        if (is_mul_op(op_reg)) begin
            iter_ovf = |iter_hi;
        end else if (op_reg == OP_MOD) begin
            iter_res = iter_hi;
        end
    end

    // Controller: accept in IDLE or DONE, wait in EXEC, pulse done once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_reg   <= OP_ADD;
            dataC    <= '0;
            done     <= 1'b0;
            zero     <= 1'b1;
            overflow <= 1'b0;
            error    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_reg <= opCode;
                        if (go_iter) begin
                            state <= EXEC;
                        end else begin
                            dataC    <= single_res;
                            overflow <= single_ovf;
                            error    <= single_err;
                            zero     <= (single_res == '0);
                            done     <= 1'b1;
                            state    <= DONE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                EXEC: begin
                    if (iter_last) begin
                        dataC    <= iter_res;
                        overflow <= iter_ovf;
                        error    <= 1'b0;
                        zero     <= (iter_res == '0);
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq: a 32-bit instance for the main function
// and an 8-bit instance for narrow-width shift, error and iteration cases.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        start = 1'b0;
    logic [4:0]  op_code = 5'd0;
    logic [31:0] data_a = '0;
    logic [31:0] data_b = '0;
    logic        ready, done, zero, overflow, error;
    logic [31:0] data_c;

    logic        start8 = 1'b0;
    logic [4:0]  op_code8 = 5'd0;
    logic [7:0]  data_a8 = '0;
    logic [7:0]  data_b8 = '0;
    logic        ready8, done8, zero8, overflow8, error8;
    logic [7:0]  data_c8;

    int assert_count = 0;
    int fail_count = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        z;
        logic        o;
        logic        e;
    } vec_t;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .opCode   (op_code),
        .dataA    (data_a),
        .dataB    (data_b),
        .ready    (ready),
        .done     (done),
        .dataC    (data_c),
        .zero     (zero),
        .overflow (overflow),
        .error    (error)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start8),
        .opCode   (op_code8),
        .dataA    (data_a8),
        .dataB    (data_b8),
        .ready    (ready8),
        .done     (done8),
        .dataC    (data_c8),
        .zero     (zero8),
        .overflow (overflow8),
        .error    (error8)
    );

    // Issue one request at a negedge, return cycles until done is seen.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        op_code = op;
        data_a  = a;
        data_b  = b;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
        assert_count++;
        if (lat < 0) begin
            fail_count++;
            $display("[TB] FAIL done_timeout op=%0d: no done within 100 cycles, required done", op);
        end
    endtask

    task automatic run_op8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                           output int lat);
        op_code8 = op;
        data_a8  = a;
        data_b8  = b;
        start8   = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (done8) begin
                lat = n;
                break;
            end
        end
        assert_count++;
        if (lat < 0) begin
            fail_count++;
            $display("[TB] FAIL done8_timeout op=%0d: no done within 100 cycles, required done", op);
        end
    endtask

    task automatic test_reset();
        int lat;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        assert_count++;
        if ({data_c, zero, overflow, error} !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
            fail_count++;
            $display("[TB] FAIL reset_outputs: got C=%h z=%b o=%b e=%b, required C=0 z=1 o=0 e=0",
                     data_c, zero, overflow, error);
        end
        assert_count++;
        if ({done, ready} !== 2'b01) begin
            fail_count++;
            $display("[TB] FAIL reset_handshake: got done=%b ready=%b, required done=0 ready=1", done, ready);
        end
        assert_count++;
        if ({data_c8, zero8, done8, ready8} !== {8'h0, 1'b1, 1'b0, 1'b1}) begin
            fail_count++;
            $display("[TB] FAIL reset_w8: got C=%h z=%b done=%b ready=%b, required C=0 z=1 done=0 ready=1",
                     data_c8, zero8, done8, ready8);
        end
        rst_n = 1'b1;
        run_op(OP_ADD, 32'd1, 32'd1, lat);
        assert_count++;
        if (lat !== 1 || data_c !== 32'd2) begin
            fail_count++;
            $display("[TB] FAIL first_start: got lat=%0d C=%h, required lat=1 C=2", lat, data_c);
        end
    endtask

    task automatic test_add();
        int lat;
        @(negedge clk);
        run_op(OP_ADD, 32'hFFFF_FFFF, 32'h1, lat);
        assert_count++;
        if (lat !== 1) begin
            fail_count++;
            $display("[TB] FAIL add_latency: got %0d, required 1", lat);
        end
        assert_count++;
        if ({data_c, zero, overflow, error} !== {32'h0, 1'b1, 1'b1, 1'b0}) begin
            fail_count++;
            $display("[TB] FAIL add_carry: got C=%h z=%b o=%b e=%b, required C=0 z=1 o=1 e=0",
                     data_c, zero, overflow, error);
        end
        @(negedge clk);
        assert_count++;
        if ({done, ready, data_c, zero} !== {1'b0, 1'b1, 32'h0, 1'b1}) begin
            fail_count++;
            $display("[TB] FAIL done_pulse_hold: got done=%b ready=%b C=%h z=%b, required done=0 ready=1 C=0 z=1",
                     done, ready, data_c, zero);
        end
    endtask

    task automatic test_mul();
        int lat;
        @(negedge clk);
        run_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, lat);
        assert_count++;
        if (lat !== 33) begin
            fail_count++;
            $display("[TB] FAIL mul_latency: got %0d, required 33", lat);
        end
        assert_count++;
        if ({data_c, zero, overflow, error} !== {32'h0, 1'b1, 1'b1, 1'b0}) begin
            fail_count++;
            $display("[TB] FAIL mul_overflow: got C=%h z=%b o=%b e=%b, required C=0 z=1 o=1 e=0",
                     data_c, zero, overflow, error);
        end
        @(negedge clk);
        run_op(OP_MULI, 32'd7, 32'd6, lat);
        assert_count++;
        if (lat !== 33 || {data_c, zero, overflow, error} !== {32'd42, 1'b0, 1'b0, 1'b0}) begin
            fail_count++;
            $display("[TB] FAIL mul_7x6: got lat=%0d C=%h z=%b o=%b e=%b, required lat=33 C=2a z=0 o=0 e=0",
                     lat, data_c, zero, overflow, error);
        end
    endtask

    task automatic test_div();
        int lat;
        @(negedge clk);
        run_op(OP_DIV, 32'd100, 32'd7, lat);
        assert_count++;
        if (lat !== 33 || {data_c, zero, overflow, error} !== {32'd14, 1'b0, 1'b0, 1'b0}) begin
            fail_count++;
            $display("[TB] FAIL div_100_7: got lat=%0d C=%h z=%b o=%b e=%b, required lat=33 C=e z=0 o=0 e=0",
                     lat, data_c, zero, overflow, error);
        end
        run_op(OP_MOD, 32'd100, 32'd7, lat);
        assert_count++;
        if (lat !== 33 || {data_c, zero, overflow, error} !== {32'd2, 1'b0, 1'b0, 1'b0}) begin
            fail_count++;
            $display("[TB] FAIL mod_100_7: got lat=%0d C=%h z=%b o=%b e=%b, required lat=33 C=2 z=0 o=0 e=0",
                     lat, data_c, zero, overflow, error);
        end
        run_op(OP_DIVI, 32'hFFFF_FFFF, 32'h0001_0000, lat);
        assert_count++;
        if (lat !== 33 || data_c !== 32'h0000_FFFF) begin
            fail_count++;
            $display("[TB] FAIL div_large: got lat=%0d C=%h, required lat=33 C=0000ffff", lat, data_c);
        end
        run_op(OP_DIV, 32'd5, 32'd0, lat);
        assert_count++;
        if (lat !== 1 || {data_c, zero, overflow, error} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
            fail_count++;
            $display("[TB] FAIL div_by_zero: got lat=%0d C=%h z=%b o=%b e=%b, required lat=1 C=0 z=1 o=0 e=1",
                     lat, data_c, zero, overflow, error);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        run_op(OP_ADD, 32'd10, 32'd20, lat);
        assert_count++;
        if (lat !== 1 || data_c !== 32'd30) begin
            fail_count++;
            $display("[TB] FAIL b2b_first: got lat=%0d C=%h, required lat=1 C=1e", lat, data_c);
        end
        run_op(OP_SUB, 32'd3, 32'd5, lat);
        assert_count++;
        if (lat !== 1 || {data_c, zero, overflow, error} !== {32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0}) begin
            fail_count++;
            $display("[TB] FAIL b2b_sub: got lat=%0d C=%h z=%b o=%b e=%b, required lat=1 C=fffffffe z=0 o=1 e=0",
                     lat, data_c, zero, overflow, error);
        end
    endtask

    task automatic test_single_ops();
        vec_t vecs[$];
        int   lat;
        vecs.push_back('{OP_SLT,  32'd3,          32'd5,          32'd1,          1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_SLTI, 32'd5,          32'd3,          32'd0,          1'b1, 1'b0, 1'b0});
        vecs.push_back('{OP_AND,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_ORI,  32'h0000_F0F0,  32'h0000_0F0F,  32'h0000_FFFF,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_NOT,  32'h0,          32'h1234,       32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_SRL,  32'h8000_0000,  32'd31,         32'd1,          1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_SRL,  32'h8000_0000,  32'd32,         32'd0,          1'b1, 1'b0, 1'b0});
        vecs.push_back('{OP_SLL,  32'd1,          32'd4,          32'd16,         1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_SLL,  32'd1,          32'd31,         32'h8000_0000,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_ADDI, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_SUBI, 32'd7,          32'd7,          32'd0,          1'b1, 1'b0, 1'b0});
        vecs.push_back('{OP_ANDI, 32'h1234_5678,  32'h0,          32'd0,          1'b1, 1'b0, 1'b0});
        vecs.push_back('{5'd25,   32'd9,          32'd9,          32'd0,          1'b1, 1'b0, 1'b1});
        vecs.push_back('{5'd31,   32'd1,          32'd2,          32'd0,          1'b1, 1'b0, 1'b1});
        foreach (vecs[i]) begin
            @(negedge clk);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            assert_count++;
            if (lat !== 1 || {data_c, zero, overflow, error} !==
                {vecs[i].c, vecs[i].z, vecs[i].o, vecs[i].e}) begin
                fail_count++;
                $display("[TB] FAIL single_op[%0d] op=%0d: got lat=%0d C=%h z=%b o=%b e=%b, required lat=1 C=%h z=%b o=%b e=%b",
                         i, vecs[i].op, lat, data_c, zero, overflow, error,
                         vecs[i].c, vecs[i].z, vecs[i].o, vecs[i].e);
            end
        end
    endtask

    task automatic test_exec_ignore();
        int dones = 0;
        int first = -1;
        @(negedge clk);
        op_code = OP_MUL;
        data_a  = 32'd7;
        data_b  = 32'd6;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (first < 0) first = n;
            end
            if (n == 5) begin
                assert_count++;
                if (ready !== 1'b0) begin
                    fail_count++;
                    $display("[TB] FAIL exec_ready: got ready=%b, required 0", ready);
                end
            end
            if (n < 20) begin
                op_code = OP_ADD;
                data_a  = 32'd1;
                data_b  = 32'd1;
                start   = n[0];
            end else begin
                start = 1'b0;
            end
        end
        assert_count++;
        if (dones !== 1 || first !== 33 || data_c !== 32'd42) begin
            fail_count++;
            $display("[TB] FAIL exec_ignore: got dones=%0d first=%0d C=%h, required dones=1 first=33 C=2a",
                     dones, first, data_c);
        end
    endtask

    task automatic test_reset_during_exec();
        int lat;
        int dones = 0;
        @(negedge clk);
        op_code = OP_DIV;
        data_a  = 32'd100;
        data_b  = 32'd7;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        assert_count++;
        if (ready !== 1'b0 || data_c !== 32'd42) begin
            fail_count++;
            $display("[TB] FAIL pre_reset_exec: got ready=%b C=%h, required ready=0 C=2a", ready, data_c);
        end
        rst_n = 1'b0;
        #1;
        assert_count++;
        if ({data_c, zero, overflow, error, done, ready} !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            fail_count++;
            $display("[TB] FAIL reset_in_exec: got C=%h z=%b o=%b e=%b done=%b ready=%b, required C=0 z=1 o=0 e=0 done=0 ready=1",
                     data_c, zero, overflow, error, done, ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        assert_count++;
        if (dones !== 0) begin
            fail_count++;
            $display("[TB] FAIL abandoned_done: got %0d done pulses, required 0", dones);
        end
        run_op(OP_ADD, 32'd2, 32'd2, lat);
        assert_count++;
        if (lat !== 1 || data_c !== 32'd4) begin
            fail_count++;
            $display("[TB] FAIL add_after_reset: got lat=%0d C=%h, required lat=1 C=4", lat, data_c);
        end
    endtask

    task automatic test_width8();
        int lat;
        @(negedge clk);
        run_op8(OP_SLL, 8'h01, 8'd8, lat);
        assert_count++;
        if (lat !== 1 || {data_c8, zero8, overflow8, error8} !== {8'h0, 1'b1, 1'b0, 1'b0}) begin
            fail_count++;
            $display("[TB] FAIL w8_sll8: got lat=%0d C=%h z=%b o=%b e=%b, required lat=1 C=0 z=1 o=0 e=0",
                     lat, data_c8, zero8, overflow8, error8);
        end
        run_op8(5'd20, 8'h55, 8'h0F, lat);
        assert_count++;
        if (lat !== 1 || {data_c8, zero8, overflow8, error8} !== {8'h0, 1'b1, 1'b0, 1'b1}) begin
            fail_count++;
            $display("[TB] FAIL w8_op20: got lat=%0d C=%h z=%b o=%b e=%b, required lat=1 C=0 z=1 o=0 e=1",
                     lat, data_c8, zero8, overflow8, error8);
        end
        run_op8(OP_SRL, 8'h80, 8'd7, lat);
        assert_count++;
        if (lat !== 1 || data_c8 !== 8'h01) begin
            fail_count++;
            $display("[TB] FAIL w8_srl7: got lat=%0d C=%h, required lat=1 C=01", lat, data_c8);
        end
        run_op8(OP_MUL, 8'd15, 8'd17, lat);
        assert_count++;
        if (lat !== 9 || {data_c8, zero8, overflow8, error8} !== {8'hFF, 1'b0, 1'b0, 1'b0}) begin
            fail_count++;
            $display("[TB] FAIL w8_mul_15x17: got lat=%0d C=%h z=%b o=%b e=%b, required lat=9 C=ff z=0 o=0 e=0",
                     lat, data_c8, zero8, overflow8, error8);
        end
        run_op8(OP_MULI, 8'd16, 8'd16, lat);
        assert_count++;
        if (lat !== 9 || {data_c8, zero8, overflow8, error8} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
            fail_count++;
            $display("[TB] FAIL w8_mul_16x16: got lat=%0d C=%h z=%b o=%b e=%b, required lat=9 C=00 z=1 o=1 e=0",
                     lat, data_c8, zero8, overflow8, error8);
        end
        run_op8(OP_DIV, 8'd200, 8'd7, lat);
        assert_count++;
        if (lat !== 9 || data_c8 !== 8'd28) begin
            fail_count++;
            $display("[TB] FAIL w8_div_200_7: got lat=%0d C=%h, required lat=9 C=1c", lat, data_c8);
        end
        run_op8(OP_MOD, 8'd200, 8'd7, lat);
        assert_count++;
        if (lat !== 9 || data_c8 !== 8'd4) begin
            fail_count++;
            $display("[TB] FAIL w8_mod_200_7: got lat=%0d C=%h, required lat=9 C=04", lat, data_c8);
        end
    endtask

    initial begin
        $display("[TB] starting alu_seq directed tests");
        test_reset();
        test_add();
        test_mul();
        test_div();
        test_back_to_back();
        test_single_ops();
        test_exec_ignore();
        test_reset_during_exec();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
